sr_cmd_conditioner: RTL and testbench
=====================================

Name: sr_cmd_conditioner

Overview:
Upstream stage of the SR latch. Takes two raw, asynchronous, bouncing request lines (set button, reset button). For each line it synchronises, debounces and edge-detects the input, then arbitrates the two. It drives clean, registered, one-cycle, mutually exclusive S and R pulses that never present the forbidden S=R=1 combination to the latch. It also keeps a registered mirror of the value the latch will hold.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per input (legal: 2 or more).
DEBOUNCE_CYCLES, 16, consecutive clock cycles a synchronised level must differ from the debounced level before it is accepted (legal: 1 or more).
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (localparam, derived, not overridable).

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous active-low reset; asserts immediately, release is synchronous to clk at the system level.
set_raw  input  1  raw asynchronous set request, active high.
rst_raw  input  1  raw asynchronous reset request, active high.
S  output  1  one-cycle set pulse to the latch, registered.
R  output  1  one-cycle reset pulse to the latch, registered.
q_mirror  output  1  registered copy of the expected latch state.
conflict  output  1  one-cycle pulse: both requests were accepted on the same cycle.

Behaviour:
- Reset (rst_n=0, asynchronous) clears the following to 0: all sync flops, debounced levels, previous-debounced levels, both counters, S, R, q_mirror and conflict.
- Synchroniser: each raw input passes through SYNC_STAGES flops. The last flop is sync_x.
- Debounce, per channel, with register db_x and counter cnt_x:
  - If sync_x == db_x: cnt_x <= 0.
  - Else if cnt_x == DEBOUNCE_CYCLES-1: db_x <= sync_x and cnt_x <= 0.
  - Else: cnt_x <= cnt_x+1.
  - A glitch at sync_x shorter than DEBOUNCE_CYCLES cycles is discarded, and the counter restarts from 0.
- Edge detect: rise_x = db_x & ~db_x_d, where db_x_d is db_x delayed by one cycle. Falling edges are ignored; releasing a button produces no pulse.
- Arbitration, registered, evaluated every cycle:
  - rise_set only: S<=1, R<=0, q_mirror<=1.
  - rise_rst only: S<=0, R<=1, q_mirror<=0.
  - Both in the same cycle: S<=0, R<=0, conflict<=1, q_mirror unchanged.
  - Neither: S, R and conflict <= 0, q_mirror unchanged.
- Invariant: S&R == 0 on every cycle, in every build.
- S, R and conflict are each high for exactly one cycle per accepted edge.
- Holding a button produces one pulse only.
- Latency: a raw level change that is stable before an edge reaches S or R after SYNC_STAGES + DEBOUNCE_CYCLES + 1 rising edges (±1 edge for the sampling phase). With the defaults this is 19 edges.
- Reset mid-operation: counters and the pipeline are cleared immediately and S/R drop to 0 asynchronously.
- Input held high through reset release: db_x restarts at 0, so a fresh pulse is issued after the full latency. This is intended: power-on with a button pressed is honoured.
- Back-to-back: a set press following a reset press produces R then S in separate cycles. Alternating presses are limited only by debounce time.

Optional Feature:
Macro SR_RESET_PRIORITY_EN.
- Defined: on simultaneous accepted edges, R<=1, S<=0 and q_mirror<=0 (reset-dominant), and conflict still pulses 1 for that cycle.
- Undefined: both pulses are dropped, as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
1. Reset: hold rst_n=0 with set_raw=1 -> S=R=q_mirror=conflict=0 throughout. Release rst_n and keep set_raw=1 -> S high for exactly 1 cycle about 7 edges later, then q_mirror=1.
2. Glitch reject: set_raw high for 3 cycles, then low -> S never asserts, q_mirror stays 0. Repeat with 6 cycles high -> one S pulse and q_mirror=1.
3. Bounce: rst_raw toggles 1,0,1,0 on each cycle, then holds 1 for 10 cycles -> exactly one R pulse, timed from the start of the stable level; q_mirror=0.
4. Hold and release: set_raw high for 50 cycles, then low for 50 cycles -> exactly one S pulse in total, no pulse on release.
5. Simultaneous: set_raw and rst_raw rise on the same edge and stay high -> conflict pulses once.
   - Macro undefined: S=R=0 and q_mirror unchanged.
   - Macro defined: R pulses and q_mirror=0.
   - Both builds: S&R is never 1.
6. Mid-operation reset: assert rst_n for 1 cycle while the counter of a pending set is at 2 -> S and R go to 0 immediately, the counter clears, and the pulse arrives a full latency after rst_n is released.

Source files
------------

// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner: conditions two raw, bouncing push-button requests (set, reset) into
// clean, registered, one-cycle, mutually exclusive S/R pulses for a downstream SR latch.
// Each channel is synchronised, debounced and rising-edge detected, then the two channels
// are arbitrated. A registered mirror of the expected latch state is kept alongside.
//
// Optional build macro SR_RESET_PRIORITY_EN: when defined, simultaneous accepted edges
// resolve reset-dominant (R pulses, mirror clears). When undefined both pulses are dropped.
// In both builds such a collision raises the one-cycle conflict flag.

module sr_cmd_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_raw,
    input  logic rst_raw,
    output logic S,
    output logic R,
    output logic q_mirror,
    output logic conflict
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value on which a differing level is finally accepted.
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel indices into the per-channel vectors.
    localparam int unsigned ChSet = 0;
    localparam int unsigned ChRst = 1;

    logic [1:0]                  raw;
    logic [1:0][SYNC_STAGES-1:0] sync_q;
    logic [1:0][SYNC_STAGES-1:0] sync_d;
    logic [1:0]                  sync_last;

    logic [1:0]                  db_q;
    logic [1:0]                  db_d;
    logic [1:0]                  db_prev_q;
    logic [1:0][CNT_W-1:0]       cnt_q;
    logic [1:0][CNT_W-1:0]       cnt_d;

    logic [1:0]                  rise;

    logic                        s_q;
    logic                        s_d;
    logic                        r_q;
    logic                        r_d;
    logic                        q_mirror_q;
    logic                        q_mirror_d;
    logic                        conflict_q;
    logic                        conflict_d;

    assign raw = {rst_raw, set_raw};

    // Synchroniser shift chains; the oldest flop feeds the debouncer.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sync_d[i]    = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            sync_last[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    // Any cycle of agreement restarts the count, so short glitches are discarded.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync_last[i] != db_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    db_d[i] = sync_last[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising edges of the debounced levels; releases produce nothing.
    assign rise = db_q & ~db_prev_q;

    // Arbitration: one-hot S/R pulses, collisions flagged and resolved without S&R.
    always_comb begin
        s_d        = 1'b0;
        r_d        = 1'b0;
        conflict_d = 1'b0;
        q_mirror_d = q_mirror_q;
        unique case ({rise[ChRst], rise[ChSet]})
            2'b01: begin
                s_d        = 1'b1;
                q_mirror_d = 1'b1;
            end
            2'b10: begin
                r_d        = 1'b1;
                q_mirror_d = 1'b0;
            end
            2'b11: begin
                conflict_d = 1'b1;
`ifdef SR_RESET_PRIORITY_EN
                r_d        = 1'b1;
                q_mirror_d = 1'b0;
`endif
            end
            default: begin
            end
        endcase
    end

    // State registers; reset clears the whole pipeline so pending presses are forgotten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            db_q       <= '0;
            db_prev_q  <= '0;
            cnt_q      <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            q_mirror_q <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            db_q       <= db_d;
            db_prev_q  <= db_q;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            q_mirror_q <= q_mirror_d;
            conflict_q <= conflict_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign q_mirror = q_mirror_q;
    assign conflict = conflict_q;

    // The latch must never see the forbidden S=R=1 combination.
    assert property (@(posedge clk) disable iff (!rst_n) !(s_q && r_q));

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Bench for sr_cmd_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// A history-based reference model predicts every output each cycle; directed scenarios
// add latency and pulse-count checks, followed by a randomised press/bounce phase.

module tb_sr_cmd_conditioner;

    localparam int Sync = 2;
    localparam int Deb  = 4;
    localparam int Lat  = Sync + Deb + 1;
`ifdef SR_RESET_PRIORITY_EN
    localparam int ResetPrio = 1;
`else
    localparam int ResetPrio = 0;
`endif

    logic clk;
    logic rst_n;
    logic set_raw;
    logic rst_raw;
    logic S;
    logic R;
    logic q_mirror;
    logic conflict;

    sr_cmd_conditioner #(
        .SYNC_STAGES    (Sync),
        .DEBOUNCE_CYCLES(Deb)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_raw (set_raw),
        .rst_raw (rst_raw),
        .S       (S),
        .R       (R),
        .q_mirror(q_mirror),
        .conflict(conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the raw input seen Sync edges earlier has
    // disagreed with the accepted level on Deb consecutive edges.
    bit hist [2][4096];
    int n_m;
    bit db_m [2];
    bit dbd_m[2];
    bit s_m, r_m, q_m, c_m;

    function automatic bit raw_at(input int ch, input int m);
        if (m < 0) return 1'b0;
        return hist[ch][m % 4096];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_m = 0;
            for (int ch = 0; ch < 2; ch++) begin
                db_m[ch]  = 1'b0;
                dbd_m[ch] = 1'b0;
            end
            s_m = 1'b0;
            r_m = 1'b0;
            q_m = 1'b0;
            c_m = 1'b0;
        end else begin
            bit rs, rr, acc;
            rs  = db_m[0] & ~dbd_m[0];
            rr  = db_m[1] & ~dbd_m[1];
            s_m = 1'b0;
            r_m = 1'b0;
            c_m = 1'b0;
            if (rs && rr) begin
                c_m = 1'b1;
                if (ResetPrio != 0) begin
                    r_m = 1'b1;
                    q_m = 1'b0;
                end
            end else if (rs) begin
                s_m = 1'b1;
                q_m = 1'b1;
            end else if (rr) begin
                r_m = 1'b1;
                q_m = 1'b0;
            end
            for (int ch = 0; ch < 2; ch++) begin
                dbd_m[ch] = db_m[ch];
                acc = 1'b1;
                for (int k = 0; k < Deb; k++) begin
                    if (raw_at(ch, n_m - k - Sync) == db_m[ch]) acc = 1'b0;
                end
                if (acc) db_m[ch] = ~db_m[ch];
            end
            hist[0][n_m % 4096] = set_raw;
            hist[1][n_m % 4096] = rst_raw;
            n_m++;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check_eq("S", int'(S), int'(s_m));
        check_eq("R", int'(R), int'(r_m));
        check_eq("q_mirror", int'(q_mirror), int'(q_m));
        check_eq("conflict", int'(conflict), int'(c_m));
        check_eq("S_and_R", int'(S & R), 0);
    end

    int s_cnt, r_cnt, c_cnt;

    task automatic clear_cnt();
        s_cnt = 0;
        r_cnt = 0;
        c_cnt = 0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            s_cnt += int'(S);
            r_cnt += int'(R);
            c_cnt += int'(conflict);
        end
    endtask

    // Edges until the selected output (0=S, 1=R, 2=conflict) pulses; -1 if never.
    task automatic edges_to(input int which, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if ((which == 0 && S) || (which == 1 && R) || (which == 2 && conflict)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int lat;
    int hold_s, hold_r;

    initial begin
        rst_n   = 1'b0;
        set_raw = 1'b1;
        rst_raw = 1'b0;

        // 1. Reset held with set pressed, then released.
        clear_cnt();
        run(5);
        check_eq("t1_rst_pulses", s_cnt + r_cnt + c_cnt, 0);
        check_eq("t1_rst_q", int'(q_mirror), 0);
        rst_n = 1'b1;
        edges_to(0, lat);
        check_eq("t1_latency", lat, Lat);
        check_eq("t1_q_with_S", int'(q_mirror), 1);
        // Asynchronous reset while S is high drops it at once.
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t1_async_S", int'(S), 0);
        check_eq("t1_async_q", int'(q_mirror), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        edges_to(0, lat);
        check_eq("t1_relatency", lat, Lat);
        clear_cnt();
        run(10);
        check_eq("t1_single_pulse", s_cnt, 0);
        set_raw = 1'b0;
        run(12);

        // 2. Glitch rejection, then an accepted short press.
        do_reset();
        clear_cnt();
        set_raw = 1'b1;
        run(3);
        set_raw = 1'b0;
        run(15);
        check_eq("t2_glitch_S", s_cnt, 0);
        check_eq("t2_glitch_q", int'(q_mirror), 0);
        clear_cnt();
        set_raw = 1'b1;
        run(6);
        set_raw = 1'b0;
        run(15);
        check_eq("t2_press_S", s_cnt, 1);
        check_eq("t2_press_q", int'(q_mirror), 1);

        // 3. Bouncing reset line settling high.
        clear_cnt();
        for (int i = 0; i < 4; i++) begin
            rst_raw = (i % 2 == 0);
            run(1);
        end
        rst_raw = 1'b1;
        edges_to(1, lat);
        check_eq("t3_latency", lat, Lat);
        check_eq("t3_bounce_R", r_cnt, 0);
        run(10);
        check_eq("t3_single_R", r_cnt, 0);
        check_eq("t3_q", int'(q_mirror), 0);
        rst_raw = 1'b0;
        run(12);

        // 4. Long hold and release.
        clear_cnt();
        set_raw = 1'b1;
        run(50);
        set_raw = 1'b0;
        run(50);
        check_eq("t4_S_count", s_cnt, 1);
        check_eq("t4_R_count", r_cnt, 0);

        // 5. Simultaneous presses (mirror is 1 going in).
        clear_cnt();
        set_raw = 1'b1;
        rst_raw = 1'b1;
        edges_to(2, lat);
        check_eq("t5_latency", lat, Lat);
        check_eq("t5_S", int'(S), 0);
        check_eq("t5_R", int'(R), ResetPrio);
        check_eq("t5_q", int'(q_mirror), 1 - ResetPrio);
        run(20);
        check_eq("t5_conflict_once", c_cnt, 0);
        check_eq("t5_no_late_S", s_cnt, 0);
        check_eq("t5_no_late_R", r_cnt, 0);
        set_raw = 1'b0;
        rst_raw = 1'b0;
        run(12);

        // 6. Reset while a pending set's counter is at 2.
        do_reset();
        set_raw = 1'b1;
        run(4);
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_S", int'(S), 0);
        check_eq("t6_async_R", int'(R), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        edges_to(0, lat);
        check_eq("t6_latency", lat, Lat);
        set_raw = 1'b0;
        run(12);

        // Randomised presses and bounces, with occasional resets.
        hold_s = 0;
        hold_r = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold_s == 0) begin
                set_raw = $urandom_range(0, 1) != 0;
                hold_s  = $urandom_range(1, 10);
            end
            if (hold_r == 0) begin
                rst_raw = $urandom_range(0, 1) != 0;
                hold_r  = $urandom_range(1, 10);
            end
            hold_s--;
            hold_r--;
            if (c % 700 == 699) begin
                #2;
                rst_n = 1'b0;
                run(1);
                rst_n = 1'b1;
            end else begin
                run(1);
            end
        end

        run(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end

endmodule
